// File: rtl/lr35902_vram_arb_pkg.sv
// VRAM arbiter shared types: FSM states, requester IDs,
// read-data select codes and the locked-read default.
package lr35902_vram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DONE,
    S_WR,
    S_WR_HOLD
  } state_t;

  typedef enum logic [1:0] {
    ID_PPU = 2'd0,
    ID_DMA = 2'd1,
    ID_CPU = 2'd2
  } req_id_t;

  typedef enum logic [1:0] {
    RSEL_ZERO,
    RSEL_DOUT,
    RSEL_LOCK
  } rsel_t;

  localparam logic [7:0] LOCK_RDATA_DEF = 8'hff;

  function automatic logic [2:0] id_onehot(req_id_t id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/lr35902_vram_prio.sv
// Fixed-priority one-hot picker: bit0 (PPU) > bit1 (DMA) > bit2 (CPU).
// Ports: req[2:0] requests in, gnt[2:0] one-hot grant out (0 if idle).
module lr35902_vram_prio (
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    if (req[0])
      gnt = 3'b001;
    else if (req[1])
      gnt = 3'b010;
    else if (req[2])
      gnt = 3'b100;
  end

endmodule

// File: rtl/lr35902_vram_arb.sv
// Single-port 8 KiB VRAM arbiter: PPU > DMA > CPU, edge-style strobes.
// Ports: ppu/dma read req+adr -> ack/rvalid; cpu req/we/adr/wdata ->
//   ack/rvalid; ppu_lock blocks CPU; rdata shared; vram_* drive the RAM.
module lr35902_vram_arb
  import lr35902_vram_arb_pkg::*;
#(
  parameter int         ADR_W      = 13,
  parameter logic [7:0] LOCK_RDATA = LOCK_RDATA_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ppu_req,
  input  logic [ADR_W-1:0] ppu_adr,
  output logic             ppu_ack,
  output logic             ppu_rvalid,
  input  logic             dma_req,
  input  logic [ADR_W-1:0] dma_adr,
  output logic             dma_ack,
  output logic             dma_rvalid,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_ack,
  output logic             cpu_rvalid,
  input  logic             ppu_lock,
  output logic [7:0]       rdata,
  output logic [ADR_W-1:0] vram_adr,
  output logic [7:0]       vram_din,
  output logic             vram_read,
  output logic             vram_write,
  input  logic [7:0]       vram_dout
);

  state_t     state_q, state_d;
  req_id_t    who_q, who_d;
  logic       dummy_q, dummy_d;
  logic       grant;
  logic [2:0] gnt;

  logic [ADR_W-1:0] adr_q;
  logic [7:0]       din_q;

  logic       rd_d, wr_d;
  logic [2:0] ack_q, ack_d;
  logic [2:0] rv_q, rv_d;
  rsel_t      rsel_q, rsel_d;

  lr35902_vram_prio u_prio (
    .req ({cpu_req, dma_req, ppu_req}),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    who_d   = who_q;
    dummy_d = dummy_q;
    grant   = 1'b0;
    unique case (state_q)
      S_RD: state_d = S_RD_DONE;
      S_WR: state_d = S_WR_HOLD;
      default: begin
        state_d = S_IDLE;
        if (|gnt) begin
          grant   = 1'b1;
          // Lock is only looked at here; later changes
          // do not affect the access already granted.
          dummy_d = gnt[2] & ppu_lock;
          state_d = (gnt[2] && cpu_we) ? S_WR : S_RD;
          unique case (1'b1)
            gnt[0]:  who_d = ID_PPU;
            gnt[1]:  who_d = ID_DMA;
            default: who_d = ID_CPU;
          endcase
        end
      end
    endcase
  end

  // Outputs are registered: derive them from the next state.
  always_comb begin
    rd_d   = (state_d == S_RD) && !dummy_d;
    wr_d   = (state_d == S_WR) && !dummy_d;
    ack_d  = 3'b000;
    rv_d   = 3'b000;
    rsel_d = RSEL_ZERO;
    if (state_d == S_RD || state_d == S_WR)
      ack_d = id_onehot(who_d);
    if (state_d == S_RD_DONE) begin
      rv_d   = id_onehot(who_d);
      rsel_d = dummy_d ? RSEL_LOCK : RSEL_DOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      who_q      <= ID_PPU;
      dummy_q    <= 1'b0;
      vram_read  <= 1'b0;
      vram_write <= 1'b0;
      ack_q      <= 3'b000;
      rv_q       <= 3'b000;
      rsel_q     <= RSEL_ZERO;
    end else begin
      state_q    <= state_d;
      who_q      <= who_d;
      dummy_q    <= dummy_d;
      vram_read  <= rd_d;
      vram_write <= wr_d;
      ack_q      <= ack_d;
      rv_q       <= rv_d;
      rsel_q     <= rsel_d;
    end
  end

  // No reset: a write cut short by reset still
  // commits because adr/din stay put as write falls.
  always_ff @(posedge clk) begin
    if (!reset && grant) begin
      unique case (1'b1)
        gnt[0]:  adr_q <= ppu_adr;
        gnt[1]:  adr_q <= dma_adr;
        default: adr_q <= cpu_adr;
      endcase
      if (gnt[2] && cpu_we)
        din_q <= cpu_wdata;
    end
  end

  assign vram_adr   = adr_q;
  assign vram_din   = din_q;
  assign ppu_ack    = ack_q[ID_PPU];
  assign dma_ack    = ack_q[ID_DMA];
  assign cpu_ack    = ack_q[ID_CPU];
  assign ppu_rvalid = rv_q[ID_PPU];
  assign dma_rvalid = rv_q[ID_DMA];
  assign cpu_rvalid = rv_q[ID_CPU];

  always_comb begin
    unique case (rsel_q)
      RSEL_DOUT: rdata = vram_dout;
      RSEL_LOCK: rdata = LOCK_RDATA;
      default:   rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_lr35902_vram_arb.sv
// Bench for lr35902_vram_arb: edge-strobed VRAM model plus
// a reference memory image updated from the bench's own requests.
module tb_lr35902_vram_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_req, dma_req, cpu_req, cpu_we, ppu_lock;
  logic [12:0] ppu_adr, dma_adr, cpu_adr;
  logic [7:0]  cpu_wdata;
  logic        ppu_ack, ppu_rvalid;
  logic        dma_ack, dma_rvalid;
  logic        cpu_ack, cpu_rvalid;
  logic [7:0]  rdata;
  logic [12:0] vram_adr;
  logic [7:0]  vram_din, vram_dout;
  logic        vram_read, vram_write;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [8192];
  logic [7:0] ref_mem [8192];
  logic       prev_r = 1'b0;
  logic       prev_w = 1'b0;

  always #5 clk = ~clk;

  lr35902_vram_arb dut (
    .clk        (clk),
    .reset      (reset),
    .ppu_req    (ppu_req),
    .ppu_adr    (ppu_adr),
    .ppu_ack    (ppu_ack),
    .ppu_rvalid (ppu_rvalid),
    .dma_req    (dma_req),
    .dma_adr    (dma_adr),
    .dma_ack    (dma_ack),
    .dma_rvalid (dma_rvalid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .ppu_lock   (ppu_lock),
    .rdata      (rdata),
    .vram_adr   (vram_adr),
    .vram_din   (vram_din),
    .vram_read  (vram_read),
    .vram_write (vram_write),
    .vram_dout  (vram_dout)
  );

  // VRAM: read samples on rising read, write commits as write falls.
  always @(posedge clk) begin
    if (vram_read && !prev_r)
      vram_dout <= mem[vram_adr];
    if (!vram_write && prev_w)
      mem[vram_adr] = vram_din;
    prev_r <= vram_read;
    prev_w <= vram_write;
  end

  task automatic do_cpu(input logic we, input logic [12:0] a,
                        input logic [7:0] d, input logic lk,
                        output logic ack, output logic strb,
                        output logic rv, output logic [7:0] rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = a;
    cpu_wdata = d; ppu_lock = lk;
    @(posedge clk); #1;
    ack  = cpu_ack;
    strb = we ? vram_write : vram_read;
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rv = cpu_rvalid;
    rd = rdata;
    @(negedge clk);
    ppu_lock = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vram_read, vram_write} !== 2'b00) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00",
               {vram_read, vram_write});
    end
    checks++;
    if ({ppu_ack, dma_ack, cpu_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_acks got %b want 000",
               {ppu_ack, dma_ack, cpu_ack});
    end
    checks++;
    if ({ppu_rvalid, dma_rvalid, cpu_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rvalids got %b want 000",
               {ppu_rvalid, dma_rvalid, cpu_rvalid});
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h want 00", rdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    logic ack, strb, rv;
    logic [7:0] rd;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_adr = 13'h0010; cpu_wdata = 8'ha5;
    @(posedge clk); #1;
    checks++;
    if ({cpu_ack, vram_write} !== 2'b11) begin
      errors++;
      $display("FAIL wr_ack_strobe got %b want 11",
               {cpu_ack, vram_write});
    end
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({vram_write, cpu_ack, cpu_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL wr_hold got %b want 000",
               {vram_write, cpu_ack, cpu_rvalid});
    end
    checks++;
    if (vram_adr !== 13'h0010 || vram_din !== 8'ha5) begin
      errors++;
      $display("FAIL wr_hold_adr got %h/%h want 0010/a5",
               vram_adr, vram_din);
    end
    ref_mem[13'h0010] = 8'ha5;
    do_cpu(1'b0, 13'h0010, 8'h00, 1'b0, ack, strb, rv, rd);
    checks++;
    if ({ack, strb, rv} !== 3'b111 || rd !== 8'ha5) begin
      errors++;
      $display("FAIL rd_back got %b/%h want 111/a5",
               {ack, strb, rv}, rd);
    end
  endtask

  task automatic test_priority;
    for (int p = 0; p < 2; p++) begin
      logic [12:0] ha, ca;
      logic hack, hrv;
      ha = 13'($urandom);
      ca = 13'($urandom);
      @(negedge clk);
      if (p == 0) begin
        ppu_req = 1'b1; ppu_adr = ha;
      end else begin
        dma_req = 1'b1; dma_adr = ha;
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = ca;
      @(posedge clk); #1;
      hack = (p == 0) ? ppu_ack : dma_ack;
      checks++;
      if ({hack, cpu_ack, ppu_ack & dma_ack} !== 3'b100) begin
        errors++;
        $display("FAIL prio%0d_first got %b want 100",
                 p, {hack, cpu_ack, ppu_ack & dma_ack});
      end
      @(negedge clk);
      ppu_req = 1'b0;
      dma_req = 1'b0;
      @(posedge clk); #1;
      hrv = (p == 0) ? ppu_rvalid : dma_rvalid;
      checks++;
      if ({hrv, cpu_ack} !== 2'b10 || rdata !== ref_mem[ha]) begin
        errors++;
        $display("FAIL prio%0d_rvalid got %b/%h want 10/%h",
                 p, {hrv, cpu_ack}, rdata, ref_mem[ha]);
      end
      @(posedge clk); #1;
      checks++;
      if (cpu_ack !== 1'b1) begin
        errors++;
        $display("FAIL prio%0d_cpu_ack got %b want 1", p, cpu_ack);
      end
      @(negedge clk);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || rdata !== ref_mem[ca]) begin
        errors++;
        $display("FAIL prio%0d_cpu_rd got %b/%h want 1/%h",
                 p, cpu_rvalid, rdata, ref_mem[ca]);
      end
    end
  endtask

  task automatic test_lock;
    logic ack, strb, rv;
    logic [7:0] rd;
    do_cpu(1'b1, 13'h0300, 8'h11, 1'b0, ack, strb, rv, rd);
    ref_mem[13'h0300] = 8'h11;
    do_cpu(1'b0, 13'h0300, 8'h00, 1'b1, ack, strb, rv, rd);
    checks++;
    if ({ack, strb, rv} !== 3'b101 || rd !== 8'hff) begin
      errors++;
      $display("FAIL lock_rd got %b/%h want 101/ff",
               {ack, strb, rv}, rd);
    end
    do_cpu(1'b1, 13'h0300, 8'h5a, 1'b1, ack, strb, rv, rd);
    checks++;
    if ({ack, strb, rv} !== 3'b100) begin
      errors++;
      $display("FAIL lock_wr got %b want 100", {ack, strb, rv});
    end
    do_cpu(1'b0, 13'h0300, 8'h00, 1'b0, ack, strb, rv, rd);
    checks++;
    if (rd !== ref_mem[13'h0300] || rv !== 1'b1) begin
      errors++;
      $display("FAIL lock_wr_dropped got %h want %h",
               rd, ref_mem[13'h0300]);
    end
  endtask

  task automatic test_dma_stream;
    int acks = 0;
    int rvs = 0;
    int last = 0;
    @(negedge clk);
    dma_adr = 13'h1800;
    dma_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (dma_ack) begin
        if (acks > 0) begin
          checks++;
          if (c - last != 2) begin
            errors++;
            $display("FAIL dma_ack_gap got %0d want 2", c - last);
          end
        end
        last = c;
        acks++;
      end
      if (dma_rvalid) begin
        checks++;
        if (rdata !== ref_mem[13'(13'h1800 + rvs)]) begin
          errors++;
          $display("FAIL dma_data%0d got %h want %h", rvs,
                   rdata, ref_mem[13'(13'h1800 + rvs)]);
        end
        rvs++;
      end
      @(negedge clk);
      if (acks >= 16)
        dma_req = 1'b0;
      else
        dma_adr = 13'(13'h1800 + acks);
    end
    checks++;
    if (acks != 16 || rvs != 16) begin
      errors++;
      $display("FAIL dma_count got %0d/%0d want 16/16", acks, rvs);
    end
  endtask

  task automatic test_reset_in_write;
    logic ack, strb, rv;
    logic [7:0] rd;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_adr = 13'h1fff; cpu_wdata = 8'h3c;
    @(posedge clk); #1;
    checks++;
    if ({cpu_ack, vram_write} !== 2'b11) begin
      errors++;
      $display("FAIL rstwr_wr got %b want 11", {cpu_ack, vram_write});
    end
    @(negedge clk);
    cpu_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({vram_write, vram_read, cpu_ack, cpu_rvalid} !== 4'b0000 ||
        vram_adr !== 13'h1fff || vram_din !== 8'h3c) begin
      errors++;
      $display("FAIL rstwr_out got %b %h/%h want 0000 1fff/3c",
               {vram_write, vram_read, cpu_ack, cpu_rvalid},
               vram_adr, vram_din);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_mem[13'h1fff] = 8'h3c;
    do_cpu(1'b0, 13'h1fff, 8'h00, 1'b0, ack, strb, rv, rd);
    checks++;
    if (rv !== 1'b1 || rd !== 8'h3c) begin
      errors++;
      $display("FAIL rstwr_readback got %b/%h want 1/3c", rv, rd);
    end
  endtask

  task automatic test_lock_mid;
    logic ack, strb, rv;
    logic [7:0] rd;
    do_cpu(1'b1, 13'h0200, 8'h42, 1'b0, ack, strb, rv, rd);
    ref_mem[13'h0200] = 8'h42;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 13'h0200;
    @(posedge clk); #1;
    checks++;
    if ({cpu_ack, vram_read} !== 2'b11) begin
      errors++;
      $display("FAIL lockmid_rd got %b want 11", {cpu_ack, vram_read});
    end
    @(negedge clk);
    cpu_req = 1'b0;
    ppu_lock = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'h42) begin
      errors++;
      $display("FAIL lockmid_data got %b/%h want 1/42",
               cpu_rvalid, rdata);
    end
    @(negedge clk);
    ppu_lock = 1'b0;
  endtask

  task automatic test_random;
    logic ack, strb, rv;
    logic [7:0] rd, d;
    logic [12:0] a;
    logic lk;
    int op;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 2));
      a  = 13'(13'h0100 + $urandom_range(0, 15));
      d  = 8'($urandom);
      lk = ($urandom_range(0, 3) == 0);
      if (op == 2) begin
        @(negedge clk);
        ppu_req = 1'b1; ppu_adr = a; ppu_lock = lk;
        @(posedge clk); #1;
        ack = ppu_ack;
        @(negedge clk);
        ppu_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ack, ppu_rvalid} !== 2'b11 || rdata !== ref_mem[a]) begin
          errors++;
          $display("FAIL rnd%0d_ppu got %b/%h want 11/%h",
                   i, {ack, ppu_rvalid}, rdata, ref_mem[a]);
        end
        @(negedge clk);
        ppu_lock = 1'b0;
      end else begin
        do_cpu(op == 0, a, d, lk, ack, strb, rv, rd);
        checks++;
        if (op == 0) begin
          if ({ack, strb, rv} !== {1'b1, !lk, 1'b0}) begin
            errors++;
            $display("FAIL rnd%0d_wr got %b want %b", i,
                     {ack, strb, rv}, {1'b1, !lk, 1'b0});
          end
          if (!lk)
            ref_mem[a] = d;
        end else begin
          if ({ack, strb, rv} !== {1'b1, !lk, 1'b1} ||
              rd !== (lk ? 8'hff : ref_mem[a])) begin
            errors++;
            $display("FAIL rnd%0d_rd got %b/%h want %b/%h", i,
                     {ack, strb, rv}, rd, {1'b1, !lk, 1'b1},
                     lk ? 8'hff : ref_mem[a]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    ppu_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    cpu_we = 1'b0; ppu_lock = 1'b0; cpu_wdata = 8'h00;
    ppu_adr = '0; dma_adr = '0; cpu_adr = '0;
    test_reset;
    test_write_read;
    test_priority;
    test_lock;
    test_dma_stream;
    test_reset_in_write;
    test_lock_mid;
    test_random;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
